// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus instruction fetch sequencer over a req/ack memory handshake
//   Parameters: RESET_PC (pc after reset), BOOT_DELAY (idle cycles after reset before first fetch, 0..15)
//   Optional feature macro: ALIGN_CHECK_EN (misaligned npc on advance traps into HALT, sticky fetch_err)
//   Ports:
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     npc, advance      next pc from the next-PC unit, loaded when the core retires the current instruction
//     pc                current pc
//     instr, instr_valid fetched word at pc and its valid flag
//     imem_req, imem_addr, imem_ack, imem_rdata  instruction memory handshake
//     fetch_err         sticky misaligned-npc trap (constant 0 without ALIGN_CHECK_EN)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int BOOT_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_err
);
  typedef enum logic [1:0] {BOOT, REQ, VALID, HALT} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [31:0] pc_n, instr_n;
  logic take, misaligned, fetch_err_n;
  assign imem_addr = {pc[31:2], 2'b00};
`ifdef ALIGN_CHECK_EN
  assign misaligned = |npc[1:0];
`else
  assign misaligned = 1'b0;
`endif
  always_comb begin
    state_n = state == BOOT  ? (cnt == 4'(BOOT_DELAY) ? REQ : BOOT) :
              state == REQ   ? (imem_ack ? VALID : REQ) :
              state == VALID ? (advance ? (misaligned ? HALT : REQ) : VALID) :
              HALT;
  end
  // Registered outputs are computed here as next values so every output leaves a flop.
  always_comb begin
    take = state == VALID && advance;
    pc_n = take ? (misaligned ? npc : {npc[31:2], 2'b00}) : pc;
    instr_n = state == REQ && imem_ack ? imem_rdata : instr;
    fetch_err_n = fetch_err | (take & misaligned);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      cnt <= 4'd0;
      pc <= RESET_PC;
      instr <= 32'd0;
      instr_valid <= 1'b0;
      imem_req <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == BOOT && cnt != 4'hf ? cnt + 4'd1 : cnt;
      pc <= pc_n;
      instr <= instr_n;
      instr_valid <= state_n == VALID;
      imem_req <= state_n == REQ;
      fetch_err <= fetch_err_n;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector bench for pc_fetch_unit
module tb_pc_fetch_unit;
`ifdef ALIGN_CHECK_EN
  localparam logic ALN = 1'b1;
`else
  localparam logic ALN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] npc = 32'd0;
  logic advance = 1'b0;
  logic imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] pc, instr, imem_addr;
  logic instr_valid, imem_req, fetch_err;
  logic [31:0] pc1, instr1, imem_addr1;
  logic instr_valid1, imem_req1, fetch_err1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .npc(npc), .advance(advance), .pc(pc), .instr(instr),
    .instr_valid(instr_valid), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_err(fetch_err)
  );
  pc_fetch_unit #(.RESET_PC(32'h0000_1000), .BOOT_DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .npc(npc), .advance(advance), .pc(pc1), .instr(instr1),
    .instr_valid(instr_valid1), .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_err(fetch_err1)
  );
  typedef struct {
    logic rst_n, adv;
    logic [31:0] npc;
    logic ack;
    logic [31:0] rdata, pc, instr;
    logic vld, req, err;
  } vec_t;
  vec_t tv[15];
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic chk_all(input int i, input logic [31:0] p, input logic [31:0] ins, input logic v, input logic r, input logic e);
    chk("pc", i, pc, p);
    chk("imem_addr", i, imem_addr, {p[31:2], 2'b00});
    chk("instr", i, instr, ins);
    chk("instr_valid", i, 32'(instr_valid), 32'(v));
    chk("imem_req", i, 32'(imem_req), 32'(r));
    chk("fetch_err", i, 32'(fetch_err), 32'(e));
  endtask
  initial begin
    int n, n1;
    tv[0]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h1234, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 32'h5000, 1'b0, 32'h0, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h3000, 32'h0, 1'b0, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hAAAA0001, 32'h3000, 32'hAAAA0001, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 32'h3004, 1'b0, 32'h0, 32'h3004, 32'hAAAA0001, 1'b0, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 32'h5000, 1'b0, 32'h0, 32'h3004, 32'hAAAA0001, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h3004, 32'hAAAA0001, 1'b0, 1'b1, 1'b0};
    tv[10] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h3004, 32'hAAAA0001, 1'b0, 1'b1, 1'b0};
    tv[11] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hBBBB0002, 32'h3004, 32'hBBBB0002, 1'b1, 1'b0, 1'b0};
    tv[12] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD0000, 32'h3004, 32'hBBBB0002, 1'b1, 1'b0, 1'b0};
    tv[13] = '{1'b1, 1'b1, 32'h3006, 1'b0, 32'h0, ALN ? 32'h3006 : 32'h3004, 32'hBBBB0002,
               1'b0, !ALN, ALN};
    tv[14] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hCCCC0003, ALN ? 32'h3006 : 32'h3004,
               ALN ? 32'hBBBB0002 : 32'hCCCC0003, !ALN, 1'b0, ALN};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst_n = tv[i].rst_n; advance = tv[i].adv; npc = tv[i].npc;
      imem_ack = tv[i].ack; imem_rdata = tv[i].rdata;
      @(posedge clk); #1;
      chk_all(i, tv[i].pc, tv[i].instr, tv[i].vld, tv[i].req, tv[i].err);
    end
    // Default build re-enters REQ at 0x3008; the trapped build must stay halted.
    @(negedge clk);
    advance = 1'b1; npc = 32'h3008; imem_ack = 1'b0;
    @(posedge clk); #1;
    chk_all(15, ALN ? 32'h3006 : 32'h3008, ALN ? 32'hBBBB0002 : 32'hCCCC0003, 1'b0, !ALN, ALN);
    advance = 1'b0;
    // Asynchronous reset mid-cycle, no clock edge in between.
    #2 rst_n = 1'b0;
    #1 chk_all(16, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("dut0_pc_reset", 16, pc1, 32'h1000);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; n1 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (imem_req1 && n1 == 0) n1 = k;
      if (imem_req) begin n = k; break; end
    end
    chk("boot_delay4_req_cycle", 17, n, 5);
    chk("boot_delay0_req_cycle", 17, n1, 1);
    chk("dut0_addr", 17, imem_addr1, 32'h1000);
    chk_all(18, 32'h3000, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk_all(19, 32'h3000, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
